// File: rtl/fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with a 1-cycle registered read port.
// A 2-entry skid buffer provides first-word-fall-through output. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW+1:0]    count,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic             err_clr,
  output logic             ovf_err,
  output logic             unf_err
`endif
);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, ram_used;
  logic             inflight_q;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [AW+1:0]    count_q, count_d;
  logic [2:0]       occ;
  logic             pop;

  assign ram_used  = wptr_q - rptr_q;
  assign full      = (ram_used == (AW+1)'(DEPTH));
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign count     = count_q;
  assign pop       = out_valid & out_ready;

  assign ram_wen   = push & ~full;
  assign ram_waddr = wptr_q[AW-1:0];
  assign ram_wdata = in_data;

  // Prefetch whenever the buffer plus the in-flight read would still leave room after this cycle's pop.
  assign occ       = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
  assign ram_ren   = (ram_used != '0) & (occ < (3'd2 + {2'b00, pop}));
  assign ram_raddr = rptr_q[AW-1:0];

  always_comb begin
    wptr_d    = wptr_q + (AW+1)'(ram_wen);
    rptr_d    = rptr_q + (AW+1)'(ram_ren);
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    // Shift on pop first, then append the returning word behind whatever remains.
    if (pop) begin
      buf_cnt_d = buf_cnt_q - 2'd1;
      if (buf_cnt_q == 2'd2) buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (buf_cnt_d == 2'd0) buf0_d = ram_rdata;
      else                   buf1_d = ram_rdata;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
    count_d = {1'b0, wptr_d - rptr_d} + (AW+2)'(ram_ren) + (AW+2)'(buf_cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= ram_ren;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (err_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push & full)            ovf_q <= 1'b1;
      if (out_ready & ~out_valid) unf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Single-clock FIFO controller that drives an external dual-port RAM (write port and registered read port, 1-cycle read latency) and consumes its read data.
- Presents a push interface upstream and a first-word-fall-through valid/ready interface downstream.
- Holds the read/write pointers, occupancy accounting and a 2-entry output skid buffer, so the output sustains one word per cycle despite the RAM read latency.
- Sits between a producer stage and a consumer stage, with the RAM instantiated alongside it.

Parameters:
- DEPTH, 16: RAM entries; power of two, minimum 4.
- WIDTH, 8: data width in bits.
- AW, $clog2(DEPTH): derived RAM address width; not overridden.

Ports:
- clk  input  1  single clock for all logic and both RAM ports.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write request; accepted when !full.
- in_data  input  WIDTH  write data, sampled with push.
- full  output  1  RAM region full; push is ignored while high.
- out_valid  output  1  out_data holds the head word.
- out_ready  input  1  consumer accepts the head word; pop = out_valid & out_ready.
- out_data  output  WIDTH  head-of-FIFO data.
- count  output  AW+2  total words held: RAM + in-flight + skid buffer.
- ram_wen  output  1  RAM write enable.
- ram_waddr  output  AW  RAM write address.
- ram_wdata  output  WIDTH  RAM write data.
- ram_ren  output  1  RAM read enable.
- ram_raddr  output  AW  RAM read address.
- ram_rdata  input  WIDTH  RAM read data, valid the cycle after ram_ren.

Behaviour:
- Reset (async, rst_n low):
  - wptr = rptr = 0 (each AW+1 bits); inflight = 0; skid buffer empty.
  - Outputs: out_valid = 0, out_data = 0, full = 0, count = 0, ram_wen = 0, ram_ren = 0.
  - Reset mid-operation discards all contents, including an in-flight read; ram_rdata is ignored until the next ram_ren.
- ram_used = wptr - rptr (AW+1 bits, modular). full = (ram_used == DEPTH), combinational from registered pointers.
- Write path:
  - ram_wen = push & !full; ram_waddr = wptr[AW-1:0]; ram_wdata = in_data; all combinational.
  - wptr increments on ram_wen and wraps naturally through the MSB.
- Read issue:
  - ram_ren = (ram_used != 0) & (buf_cnt + inflight - pop < 2); ram_raddr = rptr[AW-1:0].
  - On ram_ren: rptr increments and inflight is set for the next cycle.
- Read return: when inflight, ram_rdata is written into the skid buffer at that edge. Ordering is strict FIFO.
- Skid buffer:
  - 2 entries, buf_cnt 0..2. out_data/out_valid are the registered head entry.
  - A pop and a return in the same cycle shift and append together; buf_cnt is unchanged net.
- Latency:
  - Push into an empty FIFO at cycle 0 gives out_valid in cycle 3.
  - With out_ready held high and continuous push, throughput is 1 word per cycle.
- Simultaneous push & pop: both are honoured. full is unaffected by pop in that cycle; a push while full is dropped even if a pop occurs.
- Write/read address hazard cannot occur: reads only target entries whose write completed on an earlier edge.
- count = ram_used + inflight + buf_cnt, registered.
  - Maximum is DEPTH + 2: the buffer keeps prefetching while the RAM region refills.
  - full reflects the RAM region only.
- out_data holds its value while out_valid & !out_ready (stable-while-stalled rule). When out_valid = 0, out_data holds its last value.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN. When defined, adds two outputs:
  - ovf_err (1 bit): sticky; set by push & full.
  - unf_err (1 bit): sticky; set by out_ready & !out_valid.
  - Both clear only by reset or by the added input err_clr (1 bit, synchronous, clear takes priority over set).
- When undefined, these ports and registers do not exist and push-while-full is silently dropped.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → out_valid=0, full=0, count=0, ram_wen=0, ram_ren=0; assert rst_n mid-stream with 5 words held → all cleared next sample.
- Single word: push 0xA5 at cycle 0 with out_ready=0 → out_valid=1, out_data=0xA5 from cycle 3, held stable 10 cycles; count=1 throughout.
- Fill: DEPTH=16, push 0x00..0x11 with out_ready=0 → after 18 accepted words full=1, count=18; 19th push ignored (ram_wen=0); drain yields 0x00..0x11 in order.
- Streaming: push and out_ready both high for 100 cycles with incrementing data → after 3-cycle fill, one pop per cycle, no gaps, no loss, pointer wrap exercised.
- Random stall: 50% random push/out_ready over 1000 words → scoreboard match, count equals model each cycle, out_data stable while stalled.
- FIFO_ERR_FLAGS_EN: push while full → ovf_err=1 stays set; out_ready with empty FIFO → unf_err=1; err_clr pulse → both 0 next cycle.
